// File: rtl/gauss_pkg.sv
// gauss_pkg: shared constants and types for the 5x5 Gaussian window sequencer
package gauss_pkg;
  localparam int IMG_W_DEF = 256;
  localparam int IMG_H_DEF = 256;
  localparam int TAPS = 25;
  localparam logic [15:0] RND = 16'd128;
  localparam logic [5:0] W1D [5] = '{6'd1, 6'd4, 6'd6, 6'd4, 6'd1};
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;
  typedef struct packed {
    logic [7:0] px;
    logic [7:0] py;
    logic [7:0] dt;
  } res_t;
endpackage

// File: rtl/gauss_outq.sv
// gauss_outq: small synchronous result FIFO with push/pop/full/empty/count
module gauss_outq
  import gauss_pkg::*;
#(
  parameter int DEP = 2
)(
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         i_push,
  input  logic                         i_pop,
  input  res_t                         i_d,
  output res_t                         o_q,
  output logic                         o_full,
  output logic                         o_empty,
  output logic [$clog2(DEP+1)-1:0]     o_cnt
);
  localparam int AW = DEP > 1 ? $clog2(DEP) : 1;
  localparam int CW = $clog2(DEP + 1);
  res_t r_mem [DEP];
  logic [AW-1:0] r_wp, r_rp;
  logic [CW-1:0] r_cnt;
  logic w_push, w_pop;
  assign w_pop = i_pop && r_cnt != '0;
  assign w_push = i_push && (!o_full || w_pop);
  assign o_full = r_cnt == CW'(DEP);
  assign o_empty = r_cnt == '0;
  assign o_cnt = r_cnt;
  assign o_q = r_mem[r_rp];
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wp <= '0;
      r_rp <= '0;
      r_cnt <= '0;
      for (int i = 0; i < DEP; i++) r_mem[i] <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wp] <= i_d;
        r_wp <= r_wp == AW'(DEP - 1) ? '0 : r_wp + 1'b1;
      end
      if (w_pop) r_rp <= r_rp == AW'(DEP - 1) ? '0 : r_rp + 1'b1;
      r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
    end
  end
endmodule

// File: rtl/gauss_win_sched.sv
// gauss_win_sched: issues 5x5 window taps in raster order and accumulates Gaussian-weighted results
module gauss_win_sched
  import gauss_pkg::*;
#(
  parameter int IMG_W   = IMG_W_DEF,
  parameter int IMG_H   = IMG_H_DEF,
  parameter int RD_LAT  = 4,
  parameter int OUT_DEP = 2
)(
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       busy,
  output logic       done,
  output logic       rd_en,
  output logic [9:0] rd_px,
  output logic [9:0] rd_py,
  input  logic [7:0] rd_dt,
  input  logic       rd_vl,
  output logic       out_vl,
  input  logic       out_rdy,
  output logic [7:0] out_px,
  output logic [7:0] out_py,
  output logic [7:0] out_dt
);
  localparam int CW = $clog2(OUT_DEP + 1);
  localparam int AW = OUT_DEP > 1 ? $clog2(OUT_DEP) : 1;
  localparam int DW = $clog2(RD_LAT + 1);
  localparam int PW = $clog2(OUT_DEP * TAPS + 1);
  state_t r_st;
  logic [7:0] r_x, r_y;
  logic [2:0] r_dx, r_dy, r_rdx, r_rdy;
  logic r_in_win, r_push;
  logic [CW-1:0] r_infl;
  logic [PW-1:0] r_pend;
  logic [DW-1:0] r_disc;
  logic [15:0] r_acc;
  logic [7:0] r_cx [OUT_DEP];
  logic [7:0] r_cy [OUT_DEP];
  logic [AW-1:0] r_cwp, r_crp;
  logic [CW-1:0] w_cnt;
  logic [CW:0] w_occ;
  logic w_full, w_empty, w_pop, w_go, w_first, w_last_tap, w_last_win, w_acc_vl;
  logic [15:0] w_prod;
  logic [7:0] w_dt;
  res_t w_q, w_res;
  assign w_pop = !w_empty && out_rdy;
  assign w_occ = {1'b0, w_cnt} + {1'b0, r_infl};
  // a new window starts only when its result is guaranteed a queue slot
  assign w_go = r_st == ISSUE && (r_in_win || (!w_full && w_occ < (CW+1)'(OUT_DEP)));
  assign w_first = w_go && !r_in_win;
  assign w_last_tap = r_dx == 3'd4 && r_dy == 3'd4;
  assign w_last_win = r_x == 8'(IMG_W - 1) && r_y == 8'(IMG_H - 1);
  assign w_acc_vl = rd_vl && r_disc == '0 && r_pend != '0 && r_st != IDLE;
  assign w_prod = 16'(rd_dt) * 16'(W1D[r_rdy]) * 16'(W1D[r_rdx]);
  assign w_dt = 8'((r_acc + RND) >> 8);
  assign w_res = '{px: r_cx[r_crp], py: r_cy[r_crp], dt: w_dt};
  assign out_vl = !w_empty;
  assign out_px = w_q.px;
  assign out_py = w_q.py;
  assign out_dt = w_q.dt;
  gauss_outq #(.DEP(OUT_DEP)) u_outq (
    .clk(clk), .rst(rst), .i_push(r_push), .i_pop(w_pop), .i_d(w_res),
    .o_q(w_q), .o_full(w_full), .o_empty(w_empty), .o_cnt(w_cnt)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      r_st <= IDLE;
      busy <= 1'b0;
      done <= 1'b0;
      rd_en <= 1'b0;
      rd_px <= '0;
      rd_py <= '0;
      r_x <= '0;
      r_y <= '0;
      r_dx <= '0;
      r_dy <= '0;
      r_in_win <= 1'b0;
    end else begin
      done <= 1'b0;
      rd_en <= w_go;
      if (w_go) begin
        rd_px <= 10'(r_x) + 10'(r_dx) - 10'd2;
        rd_py <= 10'(r_y) + 10'(r_dy) - 10'd2;
        r_dx <= r_dx == 3'd4 ? 3'd0 : r_dx + 3'd1;
        r_dy <= r_dx == 3'd4 ? (r_dy == 3'd4 ? 3'd0 : r_dy + 3'd1) : r_dy;
        r_in_win <= !w_last_tap;
        if (w_last_tap) begin
          r_x <= r_x == 8'(IMG_W - 1) ? 8'd0 : r_x + 8'd1;
          if (r_x == 8'(IMG_W - 1)) r_y <= r_y == 8'(IMG_H - 1) ? 8'd0 : r_y + 8'd1;
        end
      end
      case (r_st)
        IDLE: if (start) begin
          r_st <= ISSUE;
          busy <= 1'b1;
        end
        ISSUE: if (w_go && w_last_tap && w_last_win) r_st <= DRAIN;
        DRAIN: if (w_pop && r_infl == '0 && w_cnt == CW'(1)) begin
          r_st <= DONE;
          done <= 1'b1;
        end
        default: begin
          r_st <= IDLE;
          busy <= 1'b0;
        end
      endcase
    end
  end
  // returns are only trusted once stale post-reset reads have drained
  always_ff @(posedge clk) begin
    if (rst) begin
      r_disc <= DW'(RD_LAT);
      r_pend <= '0;
      r_infl <= '0;
      r_push <= 1'b0;
      r_acc <= '0;
      r_rdx <= '0;
      r_rdy <= '0;
      r_cwp <= '0;
      r_crp <= '0;
    end else begin
      r_disc <= r_disc != '0 ? r_disc - 1'b1 : '0;
      r_pend <= r_pend + PW'(w_go) - PW'(w_acc_vl);
      r_infl <= r_infl + CW'(w_first) - CW'(r_push);
      r_push <= w_acc_vl && r_rdx == 3'd4 && r_rdy == 3'd4;
      if (w_acc_vl) begin
        r_acc <= (r_rdx == 3'd0 && r_rdy == 3'd0 ? 16'd0 : r_acc) + w_prod;
        r_rdx <= r_rdx == 3'd4 ? 3'd0 : r_rdx + 3'd1;
        r_rdy <= r_rdx == 3'd4 ? (r_rdy == 3'd4 ? 3'd0 : r_rdy + 3'd1) : r_rdy;
      end
      if (w_first) r_cwp <= r_cwp == AW'(OUT_DEP - 1) ? '0 : r_cwp + 1'b1;
      if (r_push) r_crp <= r_crp == AW'(OUT_DEP - 1) ? '0 : r_crp + 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (w_first) begin
      r_cx[r_cwp] <= r_x;
      r_cy[r_cwp] <= r_y;
    end
  end
endmodule

// File: tb/tb_gauss_win_sched.sv
// tb_gauss_win_sched: directed checks of the window sequencer on an 8x8 frame with a 4-cycle buffer model
module tb_gauss_win_sched;
  localparam int W = 8;
  localparam int H = 8;
  localparam int N = W * H;
  localparam int WT [5] = '{1, 4, 6, 4, 1};
  logic clk = 1'b0;
  logic rst, start, out_rdy, inj;
  logic busy, done, rd_en, out_vl, rd_vl;
  logic [9:0] rd_px, rd_py;
  logic [7:0] rd_dt, out_px, out_py, out_dt;
  logic [7:0] img [N];
  logic p_v [3] = '{1'b0, 1'b0, 1'b0};
  logic [9:0] p_x [3];
  logic [9:0] p_y [3];
  logic m_vl = 1'b0;
  logic [7:0] m_dt = 8'd0;
  int n_tests = 0, n_fail = 0;
  int n_res = 0, n_done = 0, n_rd = 0;
  int seq [1024];
  logic [7:0] got [N];
  logic [9:0] rdx_log [16384];
  logic [9:0] rdy_log [16384];
  always #5 clk = ~clk;
  gauss_win_sched #(.IMG_W(W), .IMG_H(H), .RD_LAT(4), .OUT_DEP(2)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .rd_en(rd_en), .rd_px(rd_px), .rd_py(rd_py), .rd_dt(rd_dt), .rd_vl(rd_vl),
    .out_vl(out_vl), .out_rdy(out_rdy), .out_px(out_px), .out_py(out_py), .out_dt(out_dt)
  );
  function automatic int mir(input int s, input int n);
    return s < 0 ? -s : s >= n ? 2 * (n - 1) - s : s;
  endfunction
  function automatic int gexp(input int x, input int y);
    int acc = 0;
    for (int dy = -2; dy <= 2; dy++)
      for (int dx = -2; dx <= 2; dx++)
        acc += WT[dy+2] * WT[dx+2] * int'(img[mir(y + dy, H) * W + mir(x + dx, W)]);
    return (acc + 128) >> 8;
  endfunction
  // image buffer: 4-cycle read latency, edge mirroring, not affected by rst
  always @(posedge clk) begin
    p_v[0] <= rd_en;
    p_x[0] <= rd_px;
    p_y[0] <= rd_py;
    for (int i = 1; i < 3; i++) begin
      p_v[i] <= p_v[i-1];
      p_x[i] <= p_x[i-1];
      p_y[i] <= p_y[i-1];
    end
    m_vl <= p_v[2];
    m_dt <= img[mir(int'($signed(p_y[2])), H) * W + mir(int'($signed(p_x[2])), W)];
  end
  assign rd_vl = m_vl | inj;
  assign rd_dt = inj ? 8'hFF : m_dt;
  always @(negedge clk) begin
    if (done) n_done++;
    if (rd_en && n_rd < 16384) begin
      rdx_log[n_rd] = rd_px;
      rdy_log[n_rd] = rd_py;
    end
    if (rd_en) n_rd++;
    if (out_vl && out_rdy) begin
      if (n_res < 1024) seq[n_res] = (out_px < W && out_py < H) ? int'(out_py) * W + int'(out_px) : -1;
      if (out_px < W && out_py < H) got[int'(out_py) * W + int'(out_px)] = out_dt;
      n_res++;
    end
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic fill(input logic [7:0] v);
    for (int i = 0; i < N; i++) img[i] = v;
  endtask
  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask
  task automatic wait_done(input string tag, input int d0);
    for (int i = 0; i < 5000 && n_done == d0; i++) @(negedge clk);
    repeat (5) tick();
    chk(tag, n_done - d0, 1);
  endtask
  task automatic chk_frame(input string tag, input int b, input int use_mdl);
    int bad = 0;
    for (int i = 0; i < N; i++) if (b + i >= 1024 || seq[b+i] != i) bad++;
    chk({tag, "_order"}, bad, 0);
    chk({tag, "_count"}, n_res - b, N);
    bad = 0;
    if (use_mdl != 0) for (int i = 0; i < N; i++) if (int'(got[i]) != gexp(i % W, i / W)) bad++;
    if (use_mdl != 0) chk({tag, "_model"}, bad, 0);
  endtask
  task automatic chk_reads(input string tag, input int rb);
    int bad = 0;
    for (int i = 0; i < N * 25; i++) begin
      int w = i / 25;
      int t = i % 25;
      logic [9:0] ex = 10'(w % W + t % 5 - 2);
      logic [9:0] ey = 10'(w / W + t / 5 - 2);
      if (rb + i >= 16384 || rdx_log[rb+i] !== ex || rdy_log[rb+i] !== ey) bad++;
    end
    chk(tag, bad, 0);
  endtask
  initial begin
    int b, rb, d0, k, r1;
    rst = 1'b1;
    start = 1'b0;
    out_rdy = 1'b1;
    inj = 1'b0;
    fill(8'd100);
    repeat (3) tick();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_rd_en", rd_en, 0);
    chk("rst_rd_px", rd_px, 0);
    chk("rst_rd_py", rd_py, 0);
    chk("rst_out_vl", out_vl, 0);
    chk("rst_out_px", out_px, 0);
    chk("rst_out_py", out_py, 0);
    chk("rst_out_dt", out_dt, 0);
    rst = 1'b0;
    repeat (6) tick();
    // uniform frame
    b = n_res; rb = n_rd; d0 = n_done;
    pulse_start();
    chk("uni_busy_on", busy, 1);
    wait_done("uni_done_once", d0);
    chk_frame("uni", b, 1);
    for (int i = 0; i < N; i++) if (got[i] != 8'd100) k++;
    chk("uni_dt100", got[0] == 8'd100 && got[N-1] == 8'd100 && got[27] == 8'd100, 1);
    chk_reads("uni_reads", rb);
    chk("uni_busy_off", busy, 0);
    // impulse at (4,4)
    fill(8'd0);
    img[4*W+4] = 8'd255;
    b = n_res; d0 = n_done;
    pulse_start();
    wait_done("imp_done", d0);
    chk_frame("imp", b, 1);
    chk("imp_4_4", got[4*W+4], 36);
    chk("imp_5_4", got[4*W+5], 24);
    chk("imp_5_5", got[5*W+5], 16);
    chk("imp_6_4", got[4*W+6], 6);
    chk("imp_6_5", got[5*W+6], 4);
    chk("imp_6_6", got[6*W+6], 1);
    chk("imp_7_4", got[4*W+7], 0);
    // stray return while idle, then corner impulse
    inj = 1'b1;
    tick();
    inj = 1'b0;
    repeat (2) tick();
    chk("idle_stray_no_out", out_vl, 0);
    fill(8'd0);
    img[0] = 8'd255;
    b = n_res; rb = n_rd; d0 = n_done;
    pulse_start();
    wait_done("cor_done", d0);
    chk("cor_first_px", rdx_log[rb], 10'h3FE);
    chk("cor_first_py", rdy_log[rb], 10'h3FE);
    chk("cor_0_0", got[0], 36);
    chk("cor_1_0", got[1], 24);
    chk("cor_0_1", got[W], 24);
    chk("cor_2_0", got[2], 6);
    chk_frame("cor", b, 1);
    // backpressure mid-frame
    fill(8'd100);
    b = n_res; rb = n_rd; d0 = n_done;
    pulse_start();
    for (int i = 0; i < 2000 && n_res - b < 10; i++) tick();
    out_rdy = 1'b0;
    k = n_res - b;
    chk("bp_fill", k >= 10, 1);
    repeat (100) tick();
    r1 = n_rd;
    chk("bp_vl", out_vl, 1);
    chk("bp_px_a", out_px, k % W);
    chk("bp_py_a", out_py, k / W);
    chk("bp_dt_a", out_dt, 100);
    repeat (100) tick();
    chk("bp_rd_stopped", n_rd - r1, 0);
    chk("bp_no_accept", n_res - b, k);
    chk("bp_px_b", out_px, k % W);
    chk("bp_py_b", out_py, k / W);
    out_rdy = 1'b1;
    wait_done("bp_done", d0);
    chk_frame("bp", b, 1);
    chk_reads("bp_reads", rb);
    // reset mid-frame with reads in flight, immediate restart
    fill(8'd0);
    img[5*W+2] = 8'd255;
    img[1*W+6] = 8'd200;
    rb = n_rd; d0 = n_done;
    pulse_start();
    for (int i = 0; i < 3000 && n_rd - rb < 20 * 25 + 7; i++) tick();
    chk("ab_reached", n_rd - rb >= 20 * 25 + 7, 1);
    rst = 1'b1;
    tick();
    chk("ab_busy", busy, 0);
    chk("ab_rd_en", rd_en, 0);
    chk("ab_out_vl", out_vl, 0);
    rst = 1'b0;
    b = n_res; rb = n_rd;
    pulse_start();
    wait_done("ab_done", d0);
    chk_frame("ab", b, 1);
    chk("ab_2_5", got[5*W+2], 36);
    chk("ab_3_5", got[5*W+3], 24);
    chk_reads("ab_reads", rb);
    // start coincident with reset
    rb = n_rd;
    rst = 1'b1;
    start = 1'b1;
    tick();
    rst = 1'b0;
    start = 1'b0;
    repeat (4) tick();
    chk("rs_busy", busy, 0);
    chk("rs_no_reads", n_rd - rb, 0);
    // start while busy
    fill(8'd0);
    img[3*W+3] = 8'd255;
    b = n_res; rb = n_rd; d0 = n_done;
    pulse_start();
    repeat (300) tick();
    pulse_start();
    wait_done("sb_done", d0);
    repeat (100) tick();
    chk("sb_done_total", n_done - d0, 1);
    chk("sb_idle", busy, 0);
    chk("sb_read_total", n_rd - rb, N * 25);
    chk_reads("sb_reads", rb);
    chk_frame("sb", b, 1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
